// File: rtl/dllp_acknak_scheduler.sv
// -----------------------------------------------------------------------------
// dllp_acknak_scheduler
//
// Receive-side Ack/Nak controller for the PCIe data link layer. It checks the
// sequence number of each received TLP against NEXT_RCV_SEQ and returns an
// accept/discard verdict one cycle later. It also schedules Ack/Nak DLLP
// requests toward the TX DLLP generator. Acks are coalesced and bounded by
// an AckNak latency timer.
//
// Optional feature macro: DLLP_ACKNAK_STATS_EN (adds saturating statistics).
//
// Parameters
//   ACKNAK_TIMER_LIMIT  cycles an accepted-but-unacked TLP may wait (>=1)
//   ACK_COALESCE_MAX    accepted TLPs that trigger an immediate Ack (1..255)
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   dl_up_i               DL_Active; low holds all state at reset values
//   tlp_vld_i/seq/good    received TLP end strobe, sequence number, LCRC ok
//   tlp_result_vld_o      verdict strobe (1 cycle after tlp_vld_i)
//   tlp_accept_o          1 = forward, 0 = discard
//   dllp_req_o/nak/seq    Ack/Nak DLLP request, type, AckNak_Seq_Num
//   dllp_gnt_i            TX side consumed the request this cycle
//   next_rcv_seq_o        current NEXT_RCV_SEQ
//   stat_good_o/dup/bad   16-bit saturating counters (DLLP_ACKNAK_STATS_EN)
// -----------------------------------------------------------------------------
module dllp_acknak_scheduler #(
    parameter int ACKNAK_TIMER_LIMIT = 255,
    parameter int ACK_COALESCE_MAX   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dl_up_i,
    input  logic        tlp_vld_i,
    input  logic [11:0] tlp_seq_i,
    input  logic        tlp_good_i,
    output logic        tlp_result_vld_o,
    output logic        tlp_accept_o,
    output logic        dllp_req_o,
    output logic        dllp_nak_o,
    output logic [11:0] dllp_seq_o,
    input  logic        dllp_gnt_i,
    output logic [11:0] next_rcv_seq_o
`ifdef DLLP_ACKNAK_STATS_EN
    ,
    output logic [15:0] stat_good_o,
    output logic [15:0] stat_dup_o,
    output logic [15:0] stat_bad_o
`endif
);

    // state   | meaning
    // IDLE    | nothing unacknowledged
    // PEND    | accepted TLPs awaiting Ack, timer running
    // REQ_ACK | Ack request presented, waiting for grant
    // REQ_NAK | Nak request presented, waiting for grant
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PEND    = 2'd1;
    localparam logic [1:0] ST_REQ_ACK = 2'd2;
    localparam logic [1:0] ST_REQ_NAK = 2'd3;

    localparam int TW = $clog2(ACKNAK_TIMER_LIMIT + 1);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(ACKNAK_TIMER_LIMIT - 1);
    localparam logic [TW-1:0] TIMER_SAT   = TW'(ACKNAK_TIMER_LIMIT);
    localparam logic [7:0]    COALESCE_LIM = 8'(ACK_COALESCE_MAX);

    logic [1:0]    state, state_n;
    logic [11:0]   next_rcv_seq, next_rcv_seq_n;
    logic [TW-1:0] timer, timer_n;
    logic [7:0]    coalesce_cnt, coalesce_cnt_n;
    logic          ack_pend, ack_pend_n;
    logic          ack_req, ack_req_n;
    logic          nak_req, nak_req_n;
    logic          nak_sched, nak_sched_n;
    logic          result_vld, result_accept;

    logic [11:0] seq_dist;
    logic        is_inorder;
    logic        is_dup;
    logic        granted;

    // Distance modulo 4096: 0 = expected, 1..2048 = already seen, else future.
    assign seq_dist   = next_rcv_seq - tlp_seq_i;
    assign is_inorder = tlp_good_i && (seq_dist == 12'd0);
    assign is_dup     = tlp_good_i && (seq_dist != 12'd0) && (seq_dist <= 12'd2048);
    assign granted    = state[1] && dllp_gnt_i;

    always_comb begin
        state_n        = state;
        next_rcv_seq_n = next_rcv_seq;
        timer_n        = timer;
        coalesce_cnt_n = coalesce_cnt;
        ack_pend_n     = ack_pend;
        ack_req_n      = ack_req;
        nak_req_n      = nak_req;
        nak_sched_n    = nak_sched;

        // Grant handling and timer step come first so that a TLP arriving in
        // the grant cycle is applied on top of the cleared state.
        case (state)
            ST_IDLE: begin
                if (ack_pend) state_n = ST_PEND;
            end
            ST_PEND: begin
                if (timer != TIMER_SAT) timer_n = timer + 1'b1;
                if (timer == TIMER_LAST || coalesce_cnt >= COALESCE_LIM || ack_req)
                    state_n = ST_REQ_ACK;
            end
            ST_REQ_ACK: begin
                if (granted) begin
                    state_n        = ST_IDLE;
                    ack_pend_n     = 1'b0;
                    coalesce_cnt_n = 8'd0;
                    timer_n        = '0;
                    ack_req_n      = 1'b0;
                end else if (timer != TIMER_SAT) begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
                // A Nak also acknowledges everything before NEXT_RCV_SEQ.
                if (granted) begin
                    state_n        = ST_IDLE;
                    nak_req_n      = 1'b0;
                    ack_pend_n     = 1'b0;
                    coalesce_cnt_n = 8'd0;
                    timer_n        = '0;
                    ack_req_n      = 1'b0;
                end
            end
        endcase

        if (tlp_vld_i) begin
            if (is_inorder) begin
                next_rcv_seq_n = next_rcv_seq + 12'd1;
                nak_sched_n    = 1'b0;
                ack_pend_n     = 1'b1;
                if (coalesce_cnt_n != 8'hFF) coalesce_cnt_n = coalesce_cnt_n + 8'd1;
                if (state_n == ST_IDLE) state_n = ST_PEND;
            end else if (is_dup) begin
                ack_req_n = 1'b1;
            end else if (!nak_sched) begin
                nak_sched_n = 1'b1;
                nak_req_n   = 1'b1;
            end
        end

        // Nak wins over any Ack; an Ack request never replaces a held Nak.
        if (nak_req_n)
            state_n = ST_REQ_NAK;
        else if (ack_req_n && !state_n[1])
            state_n = ST_REQ_ACK;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !dl_up_i) begin
            state         <= ST_IDLE;
            next_rcv_seq  <= 12'd0;
            timer         <= '0;
            coalesce_cnt  <= 8'd0;
            ack_pend      <= 1'b0;
            ack_req       <= 1'b0;
            nak_req       <= 1'b0;
            nak_sched     <= 1'b0;
            result_vld    <= 1'b0;
            result_accept <= 1'b0;
        end else begin
            state         <= state_n;
            next_rcv_seq  <= next_rcv_seq_n;
            timer         <= timer_n;
            coalesce_cnt  <= coalesce_cnt_n;
            ack_pend      <= ack_pend_n;
            ack_req       <= ack_req_n;
            nak_req       <= nak_req_n;
            nak_sched     <= nak_sched_n;
            result_vld    <= tlp_vld_i;
            result_accept <= tlp_vld_i && is_inorder;
        end
    end

    assign tlp_result_vld_o = result_vld;
    assign tlp_accept_o     = result_accept;
    assign dllp_req_o       = state[1];
    assign dllp_nak_o       = (state == ST_REQ_NAK);
    assign dllp_seq_o       = next_rcv_seq - 12'd1;
    assign next_rcv_seq_o   = next_rcv_seq;

`ifdef DLLP_ACKNAK_STATS_EN
    logic [15:0] stat_good, stat_dup, stat_bad;

    always_ff @(posedge clk_i) begin
        if (rst_i || !dl_up_i) begin
            stat_good <= 16'd0;
            stat_dup  <= 16'd0;
            stat_bad  <= 16'd0;
        end else if (tlp_vld_i) begin
            if (is_inorder) begin
                if (stat_good != 16'hFFFF) stat_good <= stat_good + 16'd1;
            end else if (is_dup) begin
                if (stat_dup != 16'hFFFF) stat_dup <= stat_dup + 16'd1;
            end else begin
                if (stat_bad != 16'hFFFF) stat_bad <= stat_bad + 16'd1;
            end
        end
    end

    assign stat_good_o = stat_good;
    assign stat_dup_o  = stat_dup;
    assign stat_bad_o  = stat_bad;
`endif

endmodule
